// File: rtl/ad9634_cfg_sequencer.sv
// AD9634 register-configuration sequencer: plays a host-filled table of 24-bit SPI
// words through the SPI controller and optionally appends the transfer/update write.
module ad9634_cfg_sequencer #(
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit AUTO_UPDATE    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [23:0]   tbl_wdata,
  input  logic [AW:0]   num_cmds,
  input  logic          start,
  input  logic          abort,
  output logic          spi_load,
  output logic [23:0]   spi_data,
  input  logic          spi_busy,
  input  logic          spi_done,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   cmd_idx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST      = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST      = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [23:0]   UPDATE_WORD = 24'h00FF01;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FINISH, S_FAIL} state_t;

  state_t          state;
  logic [23:0]     tbl [DEPTH];
  logic [AW:0]     num_lat;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;
  logic            abort_flag;

  logic [AW:0]     num_clamped;
  logic [AW:0]     next_idx;
  logic            more_words;
  logic [23:0]     cur_word;
  logic [23:0]     next_word;

  // NOTE: the table has no reset; it is plain storage the host always writes before use.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy) tbl[tbl_addr] <= tbl_wdata;
  end

  // The index equal to num_lat is the update word, never a table entry.
  always_comb begin
    num_clamped = (num_cmds > DEPTH_W) ? DEPTH_W : num_cmds;
    next_idx    = cmd_idx + 1'b1;
    more_words  = (cmd_idx != num_lat) && ((next_idx < num_lat) || AUTO_UPDATE);
    cur_word    = (cmd_idx  == num_lat) ? UPDATE_WORD : tbl[cmd_idx[AW-1:0]];
    next_word   = (next_idx == num_lat) ? UPDATE_WORD : tbl[next_idx[AW-1:0]];
  end

  // NOTE: pulse outputs default low at the top of the block; later assignments win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      spi_load   <= 1'b0;
      spi_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cmd_idx    <= '0;
      num_lat    <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
      abort_flag <= 1'b0;
    end else begin
      spi_load <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      if (state != S_IDLE && abort) abort_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_flag <= 1'b0;
          if (start) begin
            num_lat <= num_clamped;
            cmd_idx <= '0;
            if (num_clamped == '0 && !AUTO_UPDATE) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (abort_flag) begin
            state <= S_FAIL;
            error <= 1'b1;
            busy  <= 1'b0;
          end else if (!spi_busy) begin
            spi_load <= 1'b1;
            spi_data <= cur_word;
            tcnt     <= '0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (spi_done) begin
            gcnt  <= '0;
            state <= S_GAP;
          end else if (tcnt == T_LAST) begin
            state <= S_FAIL;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        // The last gap cycle doubles as the issue decision so the next load lands
        // exactly GAP_CYCLES+1 cycles after spi_done.
        S_GAP: begin
          if (gcnt != G_LAST) begin
            gcnt <= gcnt + 1'b1;
          end else if (!more_words) begin
            state <= S_FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (abort_flag) begin
            state <= S_FAIL;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cmd_idx <= next_idx;
            if (!spi_busy) begin
              spi_load <= 1'b1;
              spi_data <= next_word;
              tcnt     <= '0;
              state    <= S_WAIT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_FINISH, S_FAIL: begin
          abort_flag <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
